microwave_timer_ctrl: RTL and testbench
=======================================

# microwave_timer_ctrl

Controller that sequences the microwave's BCD countdown chain (minute-ones mod10, second-tens mod6, second-ones mod10). It accepts keypad digits, loads the chain, issues one decrement per second from a clock prescaler, and gates the magnetron enable. It handles start, stop/clear, door interlock and end-of-cook. It sits between the keypad/door inputs and the display and magnetron drivers.

## Interface
- TICKS_PER_SEC, default 100: clk cycles per one-second decrement; must be ≥2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; forces the reset state below.
- digit  in  4  keypad BCD digit.
- digit_valid  in  1  one-cycle strobe qualifying digit.
- start  in  1  one-cycle start/resume strobe.
- stop_clr  in  1  one-cycle stop (when cooking) or clear (otherwise) strobe.
- door_closed  in  1  level; 1 = door closed.
- min_ones  out  4  displayed minutes, 0–9.
- sec_tens  out  3  displayed second tens, 0–5.
- sec_ones  out  4  displayed second ones, 0–9.
- mag_on  out  1  magnetron enable; registered.
- done  out  1  level, high while in DONE.
- state  out  3  current FSM state encoding.

## Operation
- States:
  - IDLE = 0: time 0:00.
  - READY = 1: time ≠ 0, not cooking.
  - COOKING = 2.
  - PAUSED = 3.
  - DONE = 4.
- Digit entry, accepted in IDLE, READY and DONE; DONE first clears to 0:00 and then applies the digit.
  - Digits >9 are ignored.
  - The shift is left: min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit.
  - If the old sec_ones >5, the entry is rejected and the time is unchanged.
  - After an accepted entry: time ≠ 0 → READY; otherwise IDLE.
- start:
  - READY with door_closed=1 → COOKING, prescaler cleared to 0.
  - PAUSED with door_closed=1 → COOKING, prescaler value retained.
  - Ignored in IDLE, DONE, COOKING, or when the door is open.
- stop_clr:
  - COOKING → PAUSED.
  - READY, PAUSED or DONE → IDLE, digits cleared to 0:00.
  - No effect in IDLE.
- Door interlock: door_closed=0 in COOKING → PAUSED.
- Countdown in COOKING:
  - The prescaler counts 0…TICKS_PER_SEC-1 and wraps; the tick is the wrap cycle.
  - On a tick, time decrements by one second with borrow:
    - sec_ones 0→9 borrows from sec_tens.
    - sec_tens 0→5 borrows from min_ones.
  - A decrement that yields 0:00 moves the FSM to DONE in the same edge.
- DONE: done=1, time 0:00, mag_on=0. Exits via stop_clr (→ IDLE) or a digit (entry rule above).
- Priority within one cycle, highest first: reset > door open > stop_clr > tick > start > digit_valid.
  - If stop_clr or door-open coincides with a tick, the decrement is not applied.
- Reset values:
  - state = IDLE.
  - min_ones, sec_tens, sec_ones = 0.
  - mag_on = 0, done = 0.
  - Prescaler = 0.
  - Reset mid-cook aborts immediately, with no completion.

## Timing
- All outputs are registered and change only on clk edges.
- mag_on = 1 exactly while state = COOKING; it rises and falls on the same edge as the state change.
- Latencies:
  - start → COOKING and mag_on=1: one edge.
  - First decrement: TICKS_PER_SEC cycles after the start edge when starting from READY.
  - Door open → mag_on=0: the first edge that samples door_closed=0.
- Cook duration from READY at T seconds: T×TICKS_PER_SEC cycles to DONE.
- PAUSED freezes the prescaler and digits; resume continues the partial second.
- Maximum time is 9:59; no wrap beyond 0:00 (decrement from 0:00 is impossible by construction).

## Structure
- Shared package `microwave_pkg`:
  - State encoding constants (IDLE…DONE).
  - BCD digit width.
  - Digit moduli 10 and 6.
- Sub-module `bcd_down_digit`:
  - Parameters: MOD, WIDTH.
  - Ports: clk, reset, load, load_val, dec, count, borrow_out.
  - borrow_out = dec and count==0.
  - Instantiated three times, chained through borrow_out→dec.
- The FSM, digit-entry shifter and prescaler live in the top module.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset mid-count: after cooking 2 s, assert reset for one cycle → next edge shows state=IDLE, time 0:00, mag_on=0, done=0.
- Entry and countdown: digits 1,0,5 then start → display 1:05, mag_on=1 on the next edge. After 4 cycles 1:04; 1:00 → 0:59 borrows correctly; done=1 after exactly 65×4 cycles, with mag_on=0.
- Entry rejection: digits 9 then 7 → the 7 is rejected (old sec_ones 9 >5), display stays 0:09. Digits 1,2 from IDLE then start → DONE after 12 s (48 cycles).
- Door interlock: door_closed falls 2 cycles into a second at 0:10 → PAUSED, mag_on=0 next edge. Door close + start → resume; the next decrement comes 2 cycles later.
- stop_clr coinciding with tick at 0:05 → PAUSED, display stays 0:05. A second stop_clr → IDLE, 0:00.
- Start while door open in READY → ignored, state stays READY. Digit 3 in DONE → 0:03, READY, done=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared encodings and widths for the microwave timer controller.
package microwave_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned TENS_W  = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned MOD_TEN = 10;
  localparam int unsigned MOD_SIX = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/microwave_timer_ctrl_bcd_down_digit.sv
// One loadable modulo-MOD down-counting digit; borrows when decremented at zero.
module bcd_down_digit #(
  parameter int unsigned MOD   = 10,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             borrow_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = (count_q == '0) ? WIDTH'(MOD - 1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count      = count_q;
  assign borrow_out = dec && (count_q == '0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer FSM: keypad entry shifter, one-second prescaler and
// magnetron gating around a three-digit BCD countdown chain.
import microwave_pkg::*;

module microwave_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BCD_W-1:0]    digit,
  input  logic                digit_valid,
  input  logic                start,
  input  logic                stop_clr,
  input  logic                door_closed,
  output logic [BCD_W-1:0]    min_ones,
  output logic [TENS_W-1:0]   sec_tens,
  output logic [BCD_W-1:0]    sec_ones,
  output logic                mag_on,
  output logic                done,
  output logic [STATE_W-1:0]  state
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               mag_on_q, mag_on_d;
  logic               done_q, done_d;

  logic               tick_c, dec_c, clr_c, ent_c, load_c;
  logic               ones_borrow, tens_borrow, min_borrow;
  logic [TENS_W-1:0]  base_tens;
  logic [BCD_W-1:0]   base_ones;
  logic [BCD_W-1:0]   new_min, new_ones, ld_min, ld_ones;
  logic [TENS_W-1:0]  new_tens, ld_tens;
  logic               entry_ok, new_nz, time_is_one;

  assign tick_c = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
  // Door-open and stop_clr both outrank the tick, so they suppress the decrement.
  assign dec_c  = (state_q == ST_COOKING) && door_closed && !stop_clr && tick_c;

  // DONE behaves as if the display were cleared before the new digit shifts in.
  assign base_tens = (state_q == ST_DONE) ? '0 : sec_tens;
  assign base_ones = (state_q == ST_DONE) ? '0 : sec_ones;
  assign new_min   = BCD_W'(base_tens);
  assign new_tens  = TENS_W'(base_ones);
  assign new_ones  = digit;
  assign new_nz    = (new_min != '0) || (new_tens != '0) || (new_ones != '0);
  assign entry_ok  = digit_valid && (digit <= BCD_W'(9)) && (base_ones <= BCD_W'(5));

  assign time_is_one = (min_ones == '0) && (sec_tens == '0) && (sec_ones == BCD_W'(1));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_c   = 1'b0;
    ent_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (entry_ok) begin
          ent_c   = 1'b1;
          state_d = new_nz ? ST_READY : ST_IDLE;
        end
      end
      ST_READY: begin
        if (stop_clr) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (start && door_closed) begin
          state_d = ST_COOKING;
          presc_d = '0;
        end else if (entry_ok) begin
          ent_c   = 1'b1;
          state_d = new_nz ? ST_READY : ST_IDLE;
        end
      end
      ST_COOKING: begin
        if (!door_closed || stop_clr) begin
          state_d = ST_PAUSED;
        end else if (tick_c) begin
          presc_d = '0;
          // An underflow out of the top digit can only mean corrupted time; end the cook.
          if (time_is_one || min_borrow) state_d = ST_DONE;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
      ST_PAUSED: begin
        if (stop_clr) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (start && door_closed) begin
          state_d = ST_COOKING;
        end
      end
      ST_DONE: begin
        if (stop_clr) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (entry_ok) begin
          ent_c   = 1'b1;
          state_d = new_nz ? ST_READY : ST_IDLE;
        end
      end
      default: begin
        clr_c   = 1'b1;
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
    mag_on_d = (state_d == ST_COOKING);
    done_d   = (state_d == ST_DONE);
  end

  assign load_c  = clr_c || ent_c;
  assign ld_min  = clr_c ? '0 : new_min;
  assign ld_tens = clr_c ? '0 : new_tens;
  assign ld_ones = clr_c ? '0 : new_ones;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  bcd_down_digit #(.MOD(MOD_TEN), .WIDTH(BCD_W)) u_sec_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_val   (ld_ones),
    .dec        (dec_c),
    .count      (sec_ones),
    .borrow_out (ones_borrow)
  );

  bcd_down_digit #(.MOD(MOD_SIX), .WIDTH(TENS_W)) u_sec_tens (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_val   (ld_tens),
    .dec        (ones_borrow),
    .count      (sec_tens),
    .borrow_out (tens_borrow)
  );

  bcd_down_digit #(.MOD(MOD_TEN), .WIDTH(BCD_W)) u_min_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_val   (ld_min),
    .dec        (tens_borrow),
    .count      (min_ones),
    .borrow_out (min_borrow)
  );

  assign mag_on = mag_on_q;
  assign done   = done_q;
  assign state  = STATE_W'(state_q);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with TICKS_PER_SEC = 4.
module tb_microwave_timer_ctrl;

  localparam int unsigned TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       start = 1'b0;
  logic       stop_clr = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       mag_on;
  logic       done;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  microwave_timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .digit_valid (digit_valid),
    .start       (start),
    .stop_clr    (stop_clr),
    .door_closed (door_closed),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop_clr = 1'b1;
    step(1);
    stop_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    vectors++;
    if ({state, mag_on, done, min_ones, sec_tens, sec_ones} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got st=%0d mag=%0b done=%0b %0d:%0d%0d want st=0 mag=0 done=0 0:00",
               state, mag_on, done, min_ones, sec_tens, sec_ones);
    end
    do_stop();
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== 14'd0) begin
      miscompares++;
      $display("FAIL stop_in_idle: got st=%0d %0d:%0d%0d want st=0 0:00", state, min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_entry_countdown();
    press(4'd1); press(4'd0); press(4'd5);
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== {3'd1, 4'd1, 3'd0, 4'd5}) begin
      miscompares++;
      $display("FAIL entry_105: got st=%0d %0d:%0d%0d want st=1 1:05", state, min_ones, sec_tens, sec_ones);
    end
    do_start();
    vectors++;
    if ({state, mag_on, min_ones, sec_tens, sec_ones} !== {3'd2, 1'b1, 4'd1, 3'd0, 4'd5}) begin
      miscompares++;
      $display("FAIL start_edge: got st=%0d mag=%0b %0d:%0d%0d want st=2 mag=1 1:05",
               state, mag_on, min_ones, sec_tens, sec_ones);
    end
    step(TPS - 1);
    vectors++;
    if ({min_ones, sec_tens, sec_ones} !== {4'd1, 3'd0, 4'd5}) begin
      miscompares++;
      $display("FAIL pre_first_tick: got %0d:%0d%0d want 1:05", min_ones, sec_tens, sec_ones);
    end
    step(1);
    vectors++;
    if ({min_ones, sec_tens, sec_ones} !== {4'd1, 3'd0, 4'd4}) begin
      miscompares++;
      $display("FAIL first_tick: got %0d:%0d%0d want 1:04", min_ones, sec_tens, sec_ones);
    end
    step(4 * TPS);
    vectors++;
    if ({min_ones, sec_tens, sec_ones} !== {4'd1, 3'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL at_100: got %0d:%0d%0d want 1:00", min_ones, sec_tens, sec_ones);
    end
    step(TPS);
    vectors++;
    if ({min_ones, sec_tens, sec_ones} !== {4'd0, 3'd5, 4'd9}) begin
      miscompares++;
      $display("FAIL borrow_059: got %0d:%0d%0d want 0:59", min_ones, sec_tens, sec_ones);
    end
    step(65 * TPS - 6 * TPS - 1);
    vectors++;
    if ({state, done, min_ones, sec_tens, sec_ones} !== {3'd2, 1'b0, 4'd0, 3'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL before_done: got st=%0d done=%0b %0d:%0d%0d want st=2 done=0 0:01",
               state, done, min_ones, sec_tens, sec_ones);
    end
    step(1);
    vectors++;
    if ({state, done, mag_on, min_ones, sec_tens, sec_ones} !== {3'd4, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL done_65s: got st=%0d done=%0b mag=%0b %0d:%0d%0d want st=4 done=1 mag=0 0:00",
               state, done, mag_on, min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_reset_midcook();
    do_stop();
    press(4'd5);
    do_start();
    step(2 * TPS);
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== {3'd2, 4'd0, 3'd0, 4'd3}) begin
      miscompares++;
      $display("FAIL cook_2s: got st=%0d %0d:%0d%0d want st=2 0:03", state, min_ones, sec_tens, sec_ones);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    vectors++;
    if ({state, mag_on, done, min_ones, sec_tens, sec_ones} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_midcook: got st=%0d mag=%0b done=%0b %0d:%0d%0d want st=0 mag=0 done=0 0:00",
               state, mag_on, done, min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_rejection();
    press(4'd9); press(4'd7);
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== {3'd1, 4'd0, 3'd0, 4'd9}) begin
      miscompares++;
      $display("FAIL reject_7: got st=%0d %0d:%0d%0d want st=1 0:09", state, min_ones, sec_tens, sec_ones);
    end
    do_stop();
    press(4'd1);
    press(4'd12);
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== {3'd1, 4'd0, 3'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL ignore_12: got st=%0d %0d:%0d%0d want st=1 0:01", state, min_ones, sec_tens, sec_ones);
    end
    press(4'd2);
    do_start();
    step(12 * TPS - 1);
    vectors++;
    if ({state, done, min_ones, sec_tens, sec_ones} !== {3'd2, 1'b0, 4'd0, 3'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL cook12_early: got st=%0d done=%0b %0d:%0d%0d want st=2 done=0 0:01",
               state, done, min_ones, sec_tens, sec_ones);
    end
    step(1);
    vectors++;
    if ({state, done, mag_on} !== {3'd4, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL cook12_done: got st=%0d done=%0b mag=%0b want st=4 done=1 mag=0", state, done, mag_on);
    end
  endtask

  task automatic test_door();
    press(4'd1); press(4'd0);
    do_start();
    step(2);
    door_closed = 1'b0;
    step(1);
    vectors++;
    if ({state, mag_on, min_ones, sec_tens, sec_ones} !== {3'd3, 1'b0, 4'd0, 3'd1, 4'd0}) begin
      miscompares++;
      $display("FAIL door_pause: got st=%0d mag=%0b %0d:%0d%0d want st=3 mag=0 0:10",
               state, mag_on, min_ones, sec_tens, sec_ones);
    end
    step(5);
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== {3'd3, 4'd0, 3'd1, 4'd0}) begin
      miscompares++;
      $display("FAIL pause_hold: got st=%0d %0d:%0d%0d want st=3 0:10", state, min_ones, sec_tens, sec_ones);
    end
    door_closed = 1'b1;
    do_start();
    step(1);
    vectors++;
    if ({state, mag_on, min_ones, sec_tens, sec_ones} !== {3'd2, 1'b1, 4'd0, 3'd1, 4'd0}) begin
      miscompares++;
      $display("FAIL resume_partial: got st=%0d mag=%0b %0d:%0d%0d want st=2 mag=1 0:10",
               state, mag_on, min_ones, sec_tens, sec_ones);
    end
    step(1);
    vectors++;
    if ({min_ones, sec_tens, sec_ones} !== {4'd0, 3'd0, 4'd9}) begin
      miscompares++;
      $display("FAIL resume_tick: got %0d:%0d%0d want 0:09", min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_stop_tick();
    do_stop(); do_stop();
    press(4'd5);
    do_start();
    step(TPS - 1);
    do_stop();
    vectors++;
    if ({state, mag_on, min_ones, sec_tens, sec_ones} !== {3'd3, 1'b0, 4'd0, 3'd0, 4'd5}) begin
      miscompares++;
      $display("FAIL stop_on_tick: got st=%0d mag=%0b %0d:%0d%0d want st=3 mag=0 0:05",
               state, mag_on, min_ones, sec_tens, sec_ones);
    end
    do_stop();
    vectors++;
    if ({state, min_ones, sec_tens, sec_ones} !== 14'd0) begin
      miscompares++;
      $display("FAIL second_stop: got st=%0d %0d:%0d%0d want st=0 0:00", state, min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_door_open_start_and_done_digit();
    press(4'd3);
    door_closed = 1'b0;
    do_start();
    vectors++;
    if ({state, mag_on} !== {3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL start_door_open: got st=%0d mag=%0b want st=1 mag=0", state, mag_on);
    end
    door_closed = 1'b1;
    do_start();
    step(3 * TPS);
    vectors++;
    if ({state, done} !== {3'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL cook3_done: got st=%0d done=%0b want st=4 done=1", state, done);
    end
    press(4'd3);
    vectors++;
    if ({state, done, min_ones, sec_tens, sec_ones} !== {3'd1, 1'b0, 4'd0, 3'd0, 4'd3}) begin
      miscompares++;
      $display("FAIL digit_in_done: got st=%0d done=%0b %0d:%0d%0d want st=1 done=0 0:03",
               state, done, min_ones, sec_tens, sec_ones);
    end
  endtask

  initial begin
    test_reset();
    test_entry_countdown();
    test_reset_midcook();
    test_rejection();
    do_stop();
    test_door();
    test_stop_tick();
    test_door_open_start_and_done_digit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
